mips_mem_sched: RTL
===================

// Module: mips_mem_sched
// PURPOSE
//  Run-control and memory-port scheduler for the 8-bit multicycle MIPS core. Owns one shared
//  byte RAM (async read, sync write) and grants it either to the core (RUN/STEP) or to a
//  host loader port (HALT). Holds the core in reset while halted, so every run starts at PC 0.
//  Supports free run and N-cycle single-step; it counts core cycles for debug.
// PARAMETERS
//  WIDTH    8   core data/address width
//  ADRBITS  6   RAM address bits (2**ADRBITS bytes); core/host addresses truncated to low bits
//  CNTW     16  width of step count and cycle counter
// PORTS
//  clk           in   1        clock
//  reset         in   1        synchronous, active-high
//  host_valid    in   1        host access request
//  host_ready    out  1        host access accepted when valid&ready
//  host_we       in   1        1=write, 0=read
//  host_adr      in   ADRBITS  host byte address
//  host_wdata    in   WIDTH    host write data
//  host_rdata    out  WIDTH    host read data, registered
//  host_rvalid   out  1        one-cycle pulse: host_rdata valid
//  run_req       in   1        pulse: start free run
//  step_req      in   1        pulse: run step_n cycles then halt
//  step_n        in   CNTW     step length, sampled with step_req
//  halt_req      in   1        pulse: stop core
//  running       out  1        1 in RUN or STEP
//  cyc_count     out  CNTW     core cycles since last start, wraps at 2**CNTW
//  cpu_reset     out  1        drives core reset
//  cpu_memread   in   1        core read strobe
//  cpu_memwrite  in   1        core write strobe
//  cpu_adr       in   WIDTH    core address
//  cpu_wdata     in   WIDTH    core write data
//  cpu_rdata     out  WIDTH    core read data (combinational from RAM)
//  mem_we        out  1        RAM write enable, written on clk rising edge
//  mem_adr       out  ADRBITS  RAM address
//  mem_wdata     out  WIDTH    RAM write data
//  mem_rdata     in   WIDTH    RAM async read data
// BEHAVIOUR
//  States: HALT, RUN, STEP. Reset -> HALT; cyc_count=0, step counter=0, host_rdata=0,
//   host_rvalid=0. Outputs decode from state: cpu_reset=1, running=0 in HALT.
//  HALT: host_ready=1; mem_adr=host_adr, mem_wdata=host_wdata, mem_we=host_valid&host_we.
//   Read accept: host_rdata<=mem_rdata at the same edge; host_rvalid=1 the next cycle only.
//   Back-to-back host accesses are allowed at one per cycle.
//  RUN/STEP: host_ready=0; mem_adr=cpu_adr[ADRBITS-1:0], mem_wdata=cpu_wdata,
//   mem_we=cpu_memwrite. cpu_rdata=mem_rdata always. cyc_count increments each cycle.
//  Transitions, evaluated each edge; priority is halt_req > step_req > run_req:
//   HALT --run_req--> RUN; HALT --step_req & step_n!=0--> STEP (load counter=step_n);
//   step_req with step_n==0 is ignored. Entering RUN/STEP clears cyc_count to 0.
//   RUN --halt_req--> HALT; STEP --halt_req or counter==1--> HALT, else counter-=1.
//   run_req/step_req are ignored in RUN/STEP; halt_req is ignored in HALT.
//  Core sees cpu_reset=0 for exactly step_n cycles in STEP (core reset to FETCH1 on 1st edge).
//  Halt/step end: a core write in the final RUN/STEP cycle completes. Core state is then
//   discarded by cpu_reset. cyc_count holds its value in HALT.
//  A host access in the same cycle as run_req/step_req completes; the state changes next cycle.
//  Reset mid-RUN/STEP: HALT next edge, no RAM write from that cycle's core strobe is blocked.
// STRUCTURE
//  Package mips_mem_sched_pkg: typedef enum logic [1:0] {HALT,RUN,STEP} schedstate_t.
//  Sub-module sched_counter #(CNTW): loadable down-counter with ==1 flag (step count).
//  cyc_count is an inline flopenr-style register. The address/data port mux is inline mux2s.
// TESTING
//  1 reset, host writes 0xAA@3, reads @3 -> host_rvalid 1 cycle later, host_rdata=0xAA.
//  2 run_req in HALT -> next cycle running=1, cpu_reset=0, host_ready=0, cyc_count counts 0,1,2..
//  3 step_req, step_n=5 -> running high exactly 5 cycles, then HALT, cyc_count=5.
//  4 halt_req+run_req same cycle in HALT -> stays HALT; halt_req+step_req in HALT -> HALT.
//  5 step_n=0 -> no state change; run_req with host_valid write -> write lands, RUN next cycle.
//  6 core loads program (host-loaded add/sb loop), halt -> host reads stored byte equals result.

Source files
------------

// File: rtl/mips_mem_sched_pkg.sv
// mips_mem_sched_pkg: scheduler state encoding shared by the run-control block
package mips_mem_sched_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2} schedstate_t;
endpackage

// File: rtl/mips_mem_sched_counter.sv
// sched_counter: loadable down-counter with a q==1 flag, used as the step budget
module sched_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic [CNTW-1:0] d,
  output logic [CNTW-1:0] q,
  output logic            is_one
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else if (load) q <= d;
    else if (en) q <= q - CNTW'(1);
  assign is_one = q == CNTW'(1);
endmodule

// File: rtl/mips_mem_sched.sv
// mips_mem_sched: run/step/halt control and shared RAM port arbitration for the multicycle MIPS core
// Host port (host_*) owns the RAM while halted; core port (cpu_*) owns it in RUN/STEP.
// run_req/step_req/halt_req are pulses; step_n is sampled with step_req.
// cpu_reset holds the core in reset while halted; cyc_count counts core cycles since the last start.
// mem_* drive an external async-read, sync-write byte RAM.
module mips_mem_sched
  import mips_mem_sched_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 6,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic               host_we,
  input  logic [ADRBITS-1:0] host_adr,
  input  logic [WIDTH-1:0]   host_wdata,
  output logic [WIDTH-1:0]   host_rdata,
  output logic               host_rvalid,
  input  logic               run_req,
  input  logic               step_req,
  input  logic [CNTW-1:0]    step_n,
  input  logic               halt_req,
  output logic               running,
  output logic [CNTW-1:0]    cyc_count,
  output logic               cpu_reset,
  input  logic               cpu_memread,
  input  logic               cpu_memwrite,
  input  logic [WIDTH-1:0]   cpu_adr,
  input  logic [WIDTH-1:0]   cpu_wdata,
  output logic [WIDTH-1:0]   cpu_rdata,
  output logic               mem_we,
  output logic [ADRBITS-1:0] mem_adr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata
);
  schedstate_t state_q, state_d;
  logic is_halt, start_step, start, host_rd, cnt_one;
  logic [CNTW-1:0] cnt_q;
  // The core's read strobe is implied by the async RAM; upper address bits fall outside the RAM.
  logic unused;
  assign unused = &{1'b0, cpu_memread, cpu_adr[WIDTH-1:ADRBITS], cnt_q};
  assign is_halt    = state_q == HALT;
  assign running    = !is_halt;
  assign cpu_reset  = is_halt;
  assign host_ready = is_halt;
  // halt_req outranks start requests even in HALT, so a simultaneous halt cancels the start.
  assign start_step = step_req && step_n != '0;
  assign start      = is_halt && !halt_req && (start_step || run_req);
  always_comb
    state_d = is_halt ? (halt_req ? HALT : start_step ? STEP : run_req ? RUN : HALT)
                      : (halt_req || (state_q == STEP && cnt_one)) ? HALT : state_q;
  always_ff @(posedge clk)
    state_q <= reset ? HALT : state_d;
  sched_counter #(.CNTW(CNTW)) u_step (
    .clk    (clk),
    .reset  (reset),
    .load   (is_halt && !halt_req && start_step),
    .en     (state_q == STEP),
    .d      (step_n),
    .q      (cnt_q),
    .is_one (cnt_one)
  );
  always_ff @(posedge clk)
    if (reset) cyc_count <= '0;
    else if (start) cyc_count <= '0;
    else if (running) cyc_count <= cyc_count + CNTW'(1);
  assign host_rd = is_halt && host_valid && !host_we;
  always_ff @(posedge clk)
    if (reset) begin
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_rd;
      if (host_rd) host_rdata <= mem_rdata;
    end
  assign mem_adr   = running ? cpu_adr[ADRBITS-1:0] : host_adr;
  assign mem_wdata = running ? cpu_wdata : host_wdata;
  assign mem_we    = running ? cpu_memwrite : host_valid && host_we;
  assign cpu_rdata = mem_rdata;
endmodule
